mat4_xform_seq: RTL

Upstream sequencer for the `dot4` engine: computes the Q8.8 product `M × v` (4×4 matrix times 4-vector) by issuing four row-by-vector dot products to an external `dot4` instance and collecting the four results. It sits between the vertex fetch/setup logic and the single shared `dot4` unit in the vertex-transform path. Its output vector feeds the perspective stage.

---
 rtl/mat4_xform_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mat4_xform_seq.sv
// mat4_xform_seq: sequences four row-by-vector dot products on a shared dot4
// engine to form the Q8.8 product M x v. It latches the operands when a job
// is accepted. It captures one result element each time dot4 signals done.
module mat4_xform_seq (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [255:0] mat,
  input  logic [15:0]  vin_x,
  input  logic [15:0]  vin_y,
  input  logic [15:0]  vin_z,
  input  logic [15:0]  vin_w,
  output logic         busy,
  output logic         done,
  output logic [15:0]  vout_x,
  output logic [15:0]  vout_y,
  output logic [15:0]  vout_z,
  output logic [15:0]  vout_w,
  output logic         dot_start,
  output logic [15:0]  dot_v1_x,
  output logic [15:0]  dot_v1_y,
  output logic [15:0]  dot_v1_z,
  output logic [15:0]  dot_v1_w,
  output logic [15:0]  dot_v2_x,
  output logic [15:0]  dot_v2_y,
  output logic [15:0]  dot_v2_z,
  output logic [15:0]  dot_v2_w,
  input  logic         dot_done,
  input  logic [15:0]  dot_result
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

  state_t             state_q, state_d;
  logic [1:0]         row_q, row_d;
  logic [255:0]       mat_q, mat_d;
  logic [3:0][15:0]   vec_q, vec_d;
  logic [3:0][15:0]   vout_q, vout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dot_start_q, dot_start_d;
  logic               dot_done_prev_q, dot_done_prev_d;
  logic               dot_rise;
  logic [63:0]        row_sel;

  // A held-high done level from the previous row must not count, so only
  // a low-to-high transition of dot_done marks completion.
  assign dot_rise = dot_done & ~dot_done_prev_q;

  // Row mux: the latched row for the current row counter, column 0 in the low bits.
  assign row_sel  = mat_q[{row_q, 6'd0} +: 64];

  assign dot_v1_x = row_sel[15:0];
  assign dot_v1_y = row_sel[31:16];
  assign dot_v1_z = row_sel[47:32];
  assign dot_v1_w = row_sel[63:48];
  assign dot_v2_x = vec_q[0];
  assign dot_v2_y = vec_q[1];
  assign dot_v2_z = vec_q[2];
  assign dot_v2_w = vec_q[3];

  assign vout_x    = vout_q[0];
  assign vout_y    = vout_q[1];
  assign vout_z    = vout_q[2];
  assign vout_w    = vout_q[3];
  assign busy      = busy_q;
  assign done      = done_q;
  assign dot_start = dot_start_q;

  // Next-state logic: accept, issue each row, wait for the dot4 rising done, finish.
  always_comb begin
    state_d         = state_q;
    row_d           = row_q;
    mat_d           = mat_q;
    vec_d           = vec_q;
    vout_d          = vout_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    dot_start_d     = 1'b0;
    dot_done_prev_d = dot_done;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mat_d       = mat;
          vec_d       = {vin_w, vin_z, vin_y, vin_x};
          row_d       = 2'd0;
          busy_d      = 1'b1;
          dot_start_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (dot_rise) begin
          vout_d[row_q] = dot_result;
          if (row_q == 2'd3) begin
            done_d  = 1'b1;
            state_d = S_FINISH;
          end else begin
            row_d       = row_q + 2'd1;
            dot_start_d = 1'b1;
            state_d     = S_ISSUE;
          end
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything, including the latches.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      row_q           <= 2'd0;
      mat_q           <= '0;
      vec_q           <= '0;
      vout_q          <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      dot_start_q     <= 1'b0;
      dot_done_prev_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      row_q           <= row_d;
      mat_q           <= mat_d;
      vec_q           <= vec_d;
      vout_q          <= vout_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      dot_start_q     <= dot_start_d;
      dot_done_prev_q <= dot_done_prev_d;
    end
  end

endmodule
